// File: rtl/jump_pkg.sv
// Shared jump-path definitions: state encoding, widths and the squeeze-to-velocity map.
package jump_pkg;

  localparam int unsigned SQZ_W       = 4;
  localparam int unsigned V_W         = 11;
  localparam int unsigned SQZ_MAX_DEF = 14;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CHARGE   = 3'd1;
  localparam logic [2:0] ST_LAUNCH   = 3'd2;
  localparam logic [2:0] ST_FLIGHT   = 3'd3;
  localparam logic [2:0] ST_WAIT_REL = 3'd4;

  // Initial velocity for a given squeeze level, computed in V_W bits.
  function automatic logic [V_W-1:0] v_of_sqz(input logic [SQZ_W-1:0] sqz,
                                              input int unsigned       v_min,
                                              input int unsigned       v_step);
    return V_W'(v_min) + V_W'(sqz) * V_W'(v_step);
  endfunction

endpackage

// File: rtl/press_charge_meter_if.sv
// Launch handshake between the charge meter (master) and the jump physics engine (slave).
interface press_charge_meter_if;

  logic                      o_launch;
  logic [jump_pkg::V_W-1:0]  o_v_init;
  logic                      i_jump_done;

  modport master (output o_launch, output o_v_init, input  i_jump_done);
  modport slave  (input  o_launch, input  o_v_init, output i_jump_done);

endinterface

// File: rtl/press_charge_meter.sv
// Converts a debounced button hold into a squeeze level, then issues a one-cycle
// launch with the matching initial velocity and waits for the flight to finish.
module press_charge_meter
  import jump_pkg::*;
#(
  parameter int unsigned SQZ_MAX        = SQZ_MAX_DEF,
  parameter int unsigned TICKS_PER_STEP = 4,
  parameter int unsigned V_MIN          = 40,
  parameter int unsigned V_STEP         = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_tick,
  input  logic                  i_enable,
  input  logic                  i_btn,
  press_charge_meter_if.master  jif,
  output logic [SQZ_W-1:0]      o_squeeze,
  output logic                  o_busy
);

  localparam int unsigned CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

  logic [2:0]       r_state;
  logic             r_btn_q;
  logic [CNT_W-1:0] r_cnt;
  logic [SQZ_W-1:0] r_squeeze;
  logic [V_W-1:0]   r_v_init;
  logic             r_launch;
  logic             r_busy;

  logic [2:0]       w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [SQZ_W-1:0] w_sqz_nx;
  logic [V_W-1:0]   w_v_nx;
  logic             w_press;

  // Next-state, squeeze, tick counter and velocity decisions.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sqz_nx   = r_squeeze;
    w_v_nx     = r_v_init;
    w_press    = i_btn & ~r_btn_q;

    case (r_state)
      ST_IDLE: begin
        if (w_press && i_enable) begin
          w_state_nx = ST_CHARGE;
          w_sqz_nx   = '0;
          w_cnt_nx   = '0;
        end
      end
      ST_CHARGE: begin
        if (!i_enable) begin
          w_state_nx = ST_IDLE;
          w_sqz_nx   = '0;
        end else if (!i_btn) begin
          // Release beats a coincident tick; a zero squeeze is a too-short press.
          if (r_squeeze == '0) begin
            w_state_nx = ST_IDLE;
          end else begin
            w_state_nx = ST_LAUNCH;
            w_v_nx     = v_of_sqz(r_squeeze, V_MIN, V_STEP);
          end
        end else if (i_tick) begin
          if (r_cnt == CNT_W'(TICKS_PER_STEP - 1)) begin
            w_cnt_nx = '0;
            if (r_squeeze != SQZ_W'(SQZ_MAX)) w_sqz_nx = r_squeeze + SQZ_W'(1);
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_LAUNCH: begin
        w_state_nx = ST_FLIGHT;
        w_sqz_nx   = '0;
      end
      ST_FLIGHT: begin
        w_sqz_nx = '0;
        if (jif.i_jump_done) w_state_nx = i_btn ? ST_WAIT_REL : ST_IDLE;
      end
      ST_WAIT_REL: begin
        if (!i_btn) w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_sqz_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_btn_q   <= 1'b0;
      r_cnt     <= '0;
      r_squeeze <= '0;
      r_v_init  <= '0;
      r_launch  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_btn_q   <= i_btn;
      r_cnt     <= w_cnt_nx;
      r_squeeze <= w_sqz_nx;
      r_v_init  <= w_v_nx;
      r_launch  <= (w_state_nx == ST_LAUNCH);
      r_busy    <= (w_state_nx != ST_IDLE);
    end
  end

  assign o_squeeze    = r_squeeze;
  assign o_busy       = r_busy;
  assign jif.o_launch = r_launch;
  assign jif.o_v_init = r_v_init;

endmodule

// File: tb/tb_press_charge_meter.sv
// Scenario bench for press_charge_meter; expected launch velocities are queued at release time.
module tb_press_charge_meter;

  logic clk;
  logic rst_n;
  logic i_tick;
  logic i_enable;
  logic i_btn;
  logic [3:0] o_squeeze;
  logic o_busy;

  press_charge_meter_if jif();

  press_charge_meter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_tick   (i_tick),
    .i_enable (i_enable),
    .i_btn    (i_btn),
    .jif      (jif),
    .o_squeeze(o_squeeze),
    .o_busy   (o_busy)
  );

  int total;
  int bad;
  int n_launch;
  logic [10:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every launch pulse must match the oldest queued expected velocity.
  always @(negedge clk) begin
    if (rst_n && jif.o_launch) begin
      logic [10:0] exp_v;
      n_launch++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_launch: got launch v_init=%0d, required no launch", jif.o_v_init);
      end else begin
        exp_v = exp_q.pop_front();
        if (jif.o_v_init !== exp_v) begin
          bad++;
          $display("FAIL launch_v_init: got %0d, required %0d", jif.o_v_init, exp_v);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      i_tick = 1'b1;
      step();
      i_tick = 1'b0;
      step();
    end
  endtask

  task automatic done_pulse();
    jif.i_jump_done = 1'b1;
    step();
    jif.i_jump_done = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (o_squeeze !== 4'd0 || o_busy !== 1'b0 || jif.o_launch !== 1'b0 || jif.o_v_init !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs: got sqz=%0d busy=%b launch=%b v=%0d, required all 0",
               o_squeeze, o_busy, jif.o_launch, jif.o_v_init);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int l0;
    l0 = n_launch;
    i_btn = 1'b1;
    step();
    total++;
    if (o_busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b, required 1", o_busy); end
    tick_n(10);
    total++;
    if (o_squeeze !== 4'd2) begin bad++; $display("FAIL basic_squeeze: got %0d, required 2", o_squeeze); end
    exp_q.push_back(11'd64);
    i_btn = 1'b0;
    step();
    total++;
    if (jif.o_launch !== 1'b1 || o_squeeze !== 4'd2) begin
      bad++;
      $display("FAIL basic_launch_cycle: got launch=%b sqz=%0d, required 1 and 2", jif.o_launch, o_squeeze);
    end
    step();
    total++;
    if (jif.o_launch !== 1'b0 || o_squeeze !== 4'd0 || jif.o_v_init !== 11'd64 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_flight: got launch=%b sqz=%0d v=%0d busy=%b, required 0 0 64 1",
               jif.o_launch, o_squeeze, jif.o_v_init, o_busy);
    end
    done_pulse();
    total++;
    if (o_busy !== 1'b0 || n_launch != l0 + 1) begin
      bad++;
      $display("FAIL basic_done: got busy=%b launches=%0d, required 0 and %0d", o_busy, n_launch - l0, 1);
    end
  endtask

  task automatic test_saturate();
    i_btn = 1'b1;
    step();
    tick_n(100);
    total++;
    if (o_squeeze !== 4'd14) begin bad++; $display("FAIL sat_squeeze: got %0d, required 14", o_squeeze); end
    exp_q.push_back(11'd208);
    i_btn = 1'b0;
    step();
    step();
    total++;
    if (jif.o_v_init !== 11'd208) begin bad++; $display("FAIL sat_v_init: got %0d, required 208", jif.o_v_init); end
    done_pulse();
  endtask

  task automatic test_short();
    i_btn = 1'b1;
    step();
    tick_n(2);
    total++;
    if (o_squeeze !== 4'd0) begin bad++; $display("FAIL short_squeeze: got %0d, required 0", o_squeeze); end
    i_btn = 1'b0;
    step();
    step();
    total++;
    if (o_busy !== 1'b0 || jif.o_launch !== 1'b0) begin
      bad++;
      $display("FAIL short_idle: got busy=%b launch=%b, required 0 0", o_busy, jif.o_launch);
    end
  endtask

  task automatic test_release_tick();
    i_btn = 1'b1;
    step();
    tick_n(3);
    i_btn  = 1'b0;
    i_tick = 1'b1;
    step();
    i_tick = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_squeeze !== 4'd0) begin
      bad++;
      $display("FAIL release_tick: got busy=%b sqz=%0d, required 0 0", o_busy, o_squeeze);
    end
    step();
  endtask

  task automatic test_abort();
    i_btn = 1'b1;
    step();
    tick_n(12);
    total++;
    if (o_squeeze !== 4'd3) begin bad++; $display("FAIL abort_charge: got %0d, required 3", o_squeeze); end
    i_enable = 1'b0;
    step();
    total++;
    if (o_busy !== 1'b0 || o_squeeze !== 4'd0) begin
      bad++;
      $display("FAIL abort_idle: got busy=%b sqz=%0d, required 0 0", o_busy, o_squeeze);
    end
    i_enable = 1'b1;
    step();
    tick_n(4);
    total++;
    if (o_busy !== 1'b0 || o_squeeze !== 4'd0) begin
      bad++;
      $display("FAIL held_no_start: got busy=%b sqz=%0d, required 0 0", o_busy, o_squeeze);
    end
    i_btn = 1'b0;
    step();
  endtask

  task automatic test_hold_through();
    i_btn = 1'b1;
    step();
    tick_n(4);
    exp_q.push_back(11'd52);
    i_btn = 1'b0;
    step();
    i_btn    = 1'b1;
    i_enable = 1'b0;
    step();
    step();
    total++;
    if (o_busy !== 1'b1 || jif.o_v_init !== 11'd52) begin
      bad++;
      $display("FAIL flight_enable_drop: got busy=%b v=%0d, required 1 52", o_busy, jif.o_v_init);
    end
    i_enable = 1'b1;
    done_pulse();
    tick_n(50);
    total++;
    if (o_busy !== 1'b1 || o_squeeze !== 4'd0) begin
      bad++;
      $display("FAIL wait_rel_hold: got busy=%b sqz=%0d, required 1 0", o_busy, o_squeeze);
    end
    i_btn = 1'b0;
    step();
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL wait_rel_exit: got busy=%b, required 0", o_busy); end
  endtask

  task automatic test_reset_mid();
    i_btn = 1'b1;
    step();
    tick_n(8);
    exp_q.push_back(11'd64);
    i_btn = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if (o_squeeze !== 4'd0 || o_busy !== 1'b0 || jif.o_launch !== 1'b0 || jif.o_v_init !== 11'd0) begin
      bad++;
      $display("FAIL mid_reset: got sqz=%0d busy=%b launch=%b v=%0d, required all 0",
               o_squeeze, o_busy, jif.o_launch, jif.o_v_init);
    end
    step();
    rst_n = 1'b1;
    step();
    done_pulse();
    step();
    total++;
    if (o_busy !== 1'b0 || jif.o_launch !== 1'b0) begin
      bad++;
      $display("FAIL done_ignored: got busy=%b launch=%b, required 0 0", o_busy, jif.o_launch);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    n_launch = 0;
    rst_n = 1'b0;
    i_tick = 1'b0;
    i_enable = 1'b1;
    i_btn = 1'b0;
    jif.i_jump_done = 1'b0;

    test_reset();
    test_basic();
    test_saturate();
    test_short();
    test_release_tick();
    test_abort();
    test_hold_through();
    test_reset_mid();

    total++;
    if (exp_q.size() != 0 || n_launch != 4) begin
      bad++;
      $display("FAIL launch_count: got launches=%0d pending=%0d, required 4 and 0", n_launch, exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
